// File: rtl/alu_sequencer.sv
// Initiator for a 16-bit combinational ALU: reads operands from a local register file,
// drives the ALU, writes the result back and returns it. Optional flags: ALU_SEQ_FLAGS_EN.
module alu_sequencer #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int REG_AW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [REG_AW-1:0] req_rs1,
  input  logic [REG_AW-1:0] req_rs2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [REG_AW-1:0] rsp_rd,
  output logic [DATA_W-1:0] rsp_data,
`ifdef ALU_SEQ_FLAGS_EN
  output logic              rsp_zero,
  output logic              rsp_carry,
`endif
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds its payload stable while valid is high and ready is low.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;

  state_t            state;
  logic [DATA_W-1:0] regs [REG_CNT];
  logic [REG_AW-1:0] op_rd;

  // Register 0 always reads as zero regardless of array contents.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [REG_AW-1:0] a);
    return (a == '0) ? '0 : regs[a];
  endfunction

  assign req_ready = (state == IDLE) && !ld_valid;
  assign dbg_data  = rd_reg(dbg_addr);

`ifdef ALU_SEQ_FLAGS_EN
  logic [DATA_W:0] sum_w;
  logic [DATA_W:0] diff_w;
  logic            carry_w;

  // Carry/borrow derived locally; the ALU's own carry is not trusted.
  assign sum_w  = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff_w = {1'b0, alu_a} - {1'b0, alu_b};

  always_comb begin
    carry_w = 1'b0;
    if (alu_sel == OP_ADD)      carry_w = sum_w[DATA_W];
    else if (alu_sel == OP_SUB) carry_w = diff_w[DATA_W];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
      op_rd     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_rd    <= '0;
      rsp_data  <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ld_valid) begin
            if (ld_addr != '0) regs[ld_addr] <= ld_data;
          end else if (req_valid) begin
            alu_a   <= rd_reg(req_rs1);
            alu_b   <= rd_reg(req_rs2);
            alu_sel <= req_op;
            op_rd   <= req_rd;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_rd    <= op_rd;
          rsp_valid <= 1'b1;
          if (op_rd != '0) regs[op_rd] <= alu_result;
`ifdef ALU_SEQ_FLAGS_EN
          rsp_zero  <= (alu_result == '0);
          rsp_carry <= carry_w;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: reference register-file model, response
// scoreboard, directed cases and a randomized run. Honours ALU_SEQ_FLAGS_EN.
module tb_alu_sequencer;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int EW = DW + AW + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_rd, req_rs1, req_rs2;
  logic [DW-1:0] alu_a, alu_b;
  logic [1:0]    alu_sel;
  logic [DW-1:0] alu_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_rd;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [EW-1:0] obs_w;
`ifdef ALU_SEQ_FLAGS_EN
  logic          rsp_zero, rsp_carry;
  assign obs_w = {rsp_carry, rsp_zero, rsp_rd, rsp_data};
`else
  assign obs_w = {2'b00, rsp_rd, rsp_data};
`endif

  alu_sequencer #(.DATA_W(DW), .REG_CNT(8), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
`endif
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] mdl [8];
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] exp_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu_ref(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // External combinational ALU.
  always_comb alu_result = alu_ref(alu_sel, alu_a, alu_b);

  function automatic logic [EW-1:0] exp_pack(input logic [1:0] op, input logic [AW-1:0] rd,
                                             input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic [DW:0]   wide;
    logic          z, c;
    r    = alu_ref(op, a, b);
    wide = DW'(a) + DW'(b) + 17'd0;
    wide = {1'b0, a} + {1'b0, b};
    z    = (r == '0);
    c    = (op == 2'd0) ? wide[DW] : (op == 2'd1) ? (a < b) : 1'b0;
`ifndef ALU_SEQ_FLAGS_EN
    z = 1'b0;
    c = 1'b0;
`endif
    return {c, z, rd, r};
  endfunction

  // scoreboard: compare each response as it is handed over
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'(1), 32'(0));
      else begin
        exp_e = exp_q.pop_front();
        check("rsp", 32'(obs_w), 32'(exp_e));
      end
    end
  end

  // driver tasks
  task automatic do_load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    if (addr != '0) mdl[addr] = data;
  endtask

  task automatic dbg_chk(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, 32'(dbg_data), 32'(exp));
  endtask

  task automatic do_op(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input int hold, input bit poke);
    logic [DW-1:0] a, b;
    logic [EW-1:0] snap;
    int t;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    a = mdl[rs1];
    b = mdl[rs2];
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("req_timeout", 32'(0), 32'(1));
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(exp_pack(op, rd, a, b));
    if (rd != '0) mdl[rd] = alu_ref(op, a, b);
    @(negedge clk);
    check("alu_a", 32'(alu_a), 32'(a));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_sel", 32'(alu_sel), 32'(op));
    check("exec_no_rsp", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    check("rsp_latency", 32'(rsp_valid), 32'(1));
    snap = obs_w;
    if (poke) begin
      req_valid = 1'b1; req_op = 2'd0; req_rd = 3'd6; req_rs1 = 3'd1; req_rs2 = 3'd1;
    end
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'(1));
      check("hold_stable", 32'(obs_w), 32'(snap));
      check("hold_req_ready", 32'(req_ready), 32'(0));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'(1));
    check("rsp_dropped", 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    rsp_ready = 1'b0; dbg_addr = '0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_alu_a", 32'(alu_a), 32'(0));
    check("rst_alu_b", 32'(alu_b), 32'(0));
    check("rst_alu_sel", 32'(alu_sel), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_rsp_rd", 32'(rsp_rd), 32'(0));
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(1));
    dbg_chk("rst_r5", 3'd5, 16'h0000);

    // directed cases
    do_load(3'd1, 16'h0005);
    do_load(3'd2, 16'h0003);
    do_op(2'd0, 3'd3, 3'd1, 3'd2, 1, 1'b0);
    dbg_chk("dbg_r3", 3'd3, 16'h0008);
    do_op(2'd1, 3'd4, 3'd2, 3'd1, 0, 1'b0);
    dbg_chk("dbg_r4", 3'd4, 16'hFFFE);
    do_load(3'd5, 16'hFFFF);
    do_load(3'd6, 16'h0001);
    do_op(2'd0, 3'd7, 3'd5, 3'd6, 2, 1'b0);
    dbg_chk("dbg_r7", 3'd7, 16'h0000);
    do_op(2'd3, 3'd0, 3'd1, 3'd2, 1, 1'b0);
    dbg_chk("dbg_r0_wb", 3'd0, 16'h0000);
    do_load(3'd0, 16'h1234);
    dbg_chk("dbg_r0_ld", 3'd0, 16'h0000);
    // operand read precedes write-back of the same register
    do_op(2'd0, 3'd1, 3'd1, 3'd1, 0, 1'b0);
    dbg_chk("dbg_r1_self", 3'd1, 16'h000A);
    // stalled response with a competing request
    do_op(2'd2, 3'd2, 3'd1, 3'd4, 5, 1'b1);

    // load and request together: load wins, request not taken
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 16'h00A5;
    req_valid = 1'b1; req_op = 2'd1; req_rd = 3'd5; req_rs1 = 3'd1; req_rs2 = 3'd2;
    @(negedge clk);
    check("ld_req_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    ld_valid = 1'b0; req_valid = 1'b0;
    mdl[6] = 16'h00A5;
    repeat (2) @(negedge clk);
    check("ld_req_no_rsp", 32'(rsp_valid), 32'(0));
    check("ld_req_sel", 32'(alu_sel), 32'(2));
    dbg_chk("ld_req_r6", 3'd6, 16'h00A5);

    // reset during EXEC abandons the operation
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'd0; req_rd = 3'd3; req_rs1 = 3'd1; req_rs2 = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("mid_rst_alu_a", 32'(alu_a), 32'(0));
    check("mid_rst_rsp_data", 32'(rsp_data), 32'(0));
    check("mid_rst_req_ready", 32'(req_ready), 32'(1));
    dbg_chk("mid_rst_r3", 3'd3, 16'h0000);
    repeat (2) @(negedge clk);
    check("mid_rst_quiet", 32'(rsp_valid), 32'(0));

    // randomized traffic
    for (int i = 1; i < 8; i++) do_load(AW'(i), DW'($urandom_range(0, 16'hFFFF)));
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(AW'($urandom_range(0, 7)), DW'($urandom_range(0, 16'hFFFF)));
      do_op(2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b0);
    end
    for (int i = 0; i < 8; i++) dbg_chk("final_reg", AW'(i), mdl[i]);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the 16-bit ALU operand interface. Accepts operation requests over a valid/ready handshake and reads two source operands from an internal register file.
- Drives a/b/sel to an external combinational ALU, captures the result one cycle later and writes it back to the register file.
- Returns the result on a valid/ready response channel.
- Sits between the instruction/control path and the ALU datapath.

Parameters:
DATA_W, 16, operand/result width (must match ALU width)
REG_CNT, 8, register-file entries
REG_AW, 3, register address width (clog2 of REG_CNT)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  register-file load strobe (honoured only in IDLE)
ld_addr  in  REG_AW  load target register
ld_data  in  DATA_W  load value
req_valid  in  1  operation request valid
req_ready  out  1  request accepted when req_valid&&req_ready at clk edge
req_op  in  2  0 add, 1 sub, 2 and, 3 or
req_rd  in  REG_AW  destination register
req_rs1  in  REG_AW  source A register
req_rs2  in  REG_AW  source B register
alu_a  out  DATA_W  ALU operand a (registered)
alu_b  out  DATA_W  ALU operand b (registered)
alu_sel  out  2  ALU select (registered)
alu_result  in  DATA_W  ALU combinational result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_rd  out  REG_AW  destination of completed op
rsp_data  out  DATA_W  computed result
dbg_addr  in  REG_AW  debug read address
dbg_data  out  DATA_W  combinational register-file read

Behaviour:
- Reset (rst_n low, async): state IDLE; all registers 0; alu_a/alu_b/alu_sel/rsp_rd/rsp_data 0; rsp_valid 0. Reset mid-operation abandons the op: no write-back, no response.
- Register 0 hardwired to zero: reads return 0, writes (load or write-back) discarded.
- req_ready = (state==IDLE) && !ld_valid. Load has priority over request in the same cycle.
- Load in IDLE: regfile[ld_addr] <= ld_data at the edge; state unchanged. Ignored outside IDLE.
- FSM:
  - IDLE: on req accept, alu_a <= reg[rs1], alu_b <= reg[rs2], alu_sel <= req_op, latch rd; go EXEC.
  - EXEC (exactly 1 cycle): sample alu_result into rsp_data; write reg[rd] (unless rd==0); rsp_rd <= rd; rsp_valid <= 1; go RESP.
  - RESP: hold rsp_valid, rsp_data and rsp_rd stable until rsp_ready. On rsp_ready, rsp_valid <= 0 and go IDLE.
- Latency: accept at edge N → result written and rsp_valid high after edge N+1. Minimum issue interval 3 cycles (rsp_ready tied high).
- alu_a/alu_b/alu_sel hold their last values outside EXEC (no toggling).
- Operand read happens before write-back; rs1==rd or rs2==rd uses the old value.
- Arithmetic is mod 2^DATA_W; overflow wraps silently (ALU's job; no checks here).
- rsp_ready while rsp_valid low: ignored.
- dbg_data is an asynchronous read and reflects a write-back from the following cycle on.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- Defined:
  - Adds outputs rsp_zero (1 bit) and rsp_carry (1 bit), registered in EXEC alongside rsp_data and reset to 0.
  - rsp_zero = (alu_result==0).
  - rsp_carry is computed locally from alu_a/alu_b with DATA_W+1-bit arithmetic, because the ALU's carry output is not relied on:
    - add: carry-out.
    - sub: borrow (1 when alu_a < alu_b unsigned).
    - and/or: 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Load r1=0x0005, r2=0x0003; req add rd=3 rs1=1 rs2=2 → alu_a=0x0005, alu_b=0x0003, alu_sel=0 in EXEC; rsp_valid one edge after accept with rsp_data=0x0008, rsp_rd=3; dbg r3=0x0008.
- Req sub rd=4 rs1=2 rs2=1 → rsp_data=0xFFFE. With ALU_SEQ_FLAGS_EN: carry=1, zero=0.
- Load r5=0xFFFF, r6=0x0001; add rd=7 → rsp_data=0x0000. With ALU_SEQ_FLAGS_EN: zero=1, carry=1.
- Req or rd=0 rs1=1 rs2=2 → rsp_data=0x0007, rsp_rd=0; dbg r0 stays 0x0000. Load r0=0x1234 → dbg r0=0x0000.
- Hold rsp_ready low 5 cycles in RESP → rsp_valid/rsp_data stable, req_ready=0, new req_valid ignored. Raise rsp_ready → IDLE next cycle, req_ready=1. Also assert ld_valid and req_valid together in IDLE → load done, req_ready=0, request not taken.
- Assert rst_n low during EXEC of add rd=3 → rsp_valid stays 0, r3 not written (reads 0 after reset), all outputs 0, state IDLE.
